// File: rtl/sar_conv_sequencer_if.sv
// SAR core and result-stream signals of the conversion sequencer.
// master = sequencer side, slave = SAR core / result consumer side.
interface sar_conv_sequencer_if;
  logic [1:0] ch_sel;
  logic       sar_cnvst;
  logic       sar_eoc;
  logic [9:0] sar_data;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [1:0] out_ch;

  modport master (
    output ch_sel, sar_cnvst, out_valid, out_data, out_ch,
    input  sar_eoc, sar_data, out_ready
  );

  modport slave (
    input  ch_sel, sar_cnvst, out_valid, out_data, out_ch,
    output sar_eoc, sar_data, out_ready
  );
endinterface

// File: rtl/sar_conv_sequencer.sv
// Round-robin SAR scan sequencer: settles the mux, runs 1/2/4/8 conversions per
// channel, averages them and hands the result out over a valid/ready stream.
module sar_conv_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int EOC_TIMEOUT   = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  ch_mask,
  input  logic [1:0]  osr_sel,
  input  logic        err_clr,
  sar_conv_sequencer_if.master bus,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    IDLE, SELECT, SETTLE, START, WAIT_EOC, ACCUM, OUTPUT
  } state_t;

  state_t      state;
  logic [1:0]  last_ch;
  logic [1:0]  osr_q;
  logic [12:0] acc;
  logic [3:0]  smp_cnt;
  logic [7:0]  tmr;
  logic [1:0]  nxt_ch;
  logic [1:0]  idx;
  logic [3:0]  n_smp;

  assign n_smp = 4'd1 << osr_q;

  // Nearest set mask bit after last_ch; scanning far-to-near lets the nearest win.
  always_comb begin
    nxt_ch = last_ch;
    idx    = last_ch;
    for (int k = 4; k >= 1; k--) begin
      idx = last_ch + 2'(k);
      if (ch_mask[idx]) nxt_ch = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_ch       <= 2'd3;
      osr_q         <= '0;
      acc           <= '0;
      smp_cnt       <= '0;
      tmr           <= '0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
      bus.ch_sel    <= '0;
      bus.sar_cnvst <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
    end else begin
      bus.sar_cnvst <= 1'b0;
      if (err_clr) err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && ch_mask != 4'd0) begin
            state <= SELECT;
            busy  <= 1'b1;
          end
        end
        SELECT: begin
          if (!enable || ch_mask == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            last_ch    <= nxt_ch;
            bus.ch_sel <= nxt_ch;
            osr_q      <= osr_sel;
            acc        <= '0;
            smp_cnt    <= '0;
            tmr        <= 8'(SETTLE_CYCLES - 1);
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (tmr == 8'd0) begin
            state         <= START;
            bus.sar_cnvst <= 1'b1;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        START: begin
          tmr   <= 8'(EOC_TIMEOUT - 1);
          state <= WAIT_EOC;
        end
        WAIT_EOC: begin
          if (bus.sar_eoc) begin
            acc     <= acc + 13'(bus.sar_data);
            smp_cnt <= smp_cnt + 4'd1;
            state   <= ACCUM;
          end else if (tmr == 8'd0) begin
            // Set after the err_clr clear above so a coincident timeout wins.
            err_timeout <= 1'b1;
            acc         <= '0;
            smp_cnt     <= '0;
            state       <= SELECT;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        ACCUM: begin
          if (smp_cnt < n_smp) begin
            state         <= START;
            bus.sar_cnvst <= 1'b1;
          end else begin
            state         <= OUTPUT;
            bus.out_valid <= 1'b1;
            bus.out_data  <= 10'(acc >> osr_q);
            bus.out_ch    <= bus.ch_sel;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= SELECT;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sar_conv_sequencer.md
SAR_CONV_SEQUENCER -- requirements
Module: sar_conv_sequencer

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 4: mux settling cycles before each conversion start, allowed range 1..255.
REQ-002 SHALL provide parameter EOC_TIMEOUT, default 63: maximum cycles from sar_cnvst to sar_eoc, allowed range 1..255.
REQ-003 SHALL provide port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL provide port enable, input, 1 bit: permits new channel scans.
REQ-006 SHALL provide port ch_mask, input, 4 bits: set bits mark the channels to convert.
REQ-007 SHALL provide port osr_sel, input, 2 bits: conversions averaged per result; 0 selects 1, 1 selects 2, 2 selects 4, 3 selects 8.
REQ-008 SHALL provide port err_clr, input, 1 bit: clears err_timeout.
REQ-009 SHALL provide port ch_sel, output, 2 bits: analog mux select.
REQ-010 SHALL provide port sar_cnvst, output, 1 bit: conversion start pulse to the SAR core.
REQ-011 SHALL provide port sar_eoc, input, 1 bit: one-cycle end-of-conversion pulse from the SAR core.
REQ-012 SHALL provide port sar_data, input, 10 bits: SAR result, valid only in the sar_eoc cycle.
REQ-013 SHALL provide port out_valid, input out_ready, output out_data (10 bits) and output out_ch (2 bits): the result stream.
REQ-014 SHALL provide port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL provide port err_timeout, output, 1 bit: sticky EOC-timeout flag.

Function
REQ-016 SHALL implement the states IDLE, SELECT, SETTLE, START, WAIT_EOC, ACCUM and OUTPUT.
REQ-017 IDLE SHALL go to SELECT when enable=1 and ch_mask!=0; otherwise it SHALL remain in IDLE.
REQ-018 SELECT SHALL, in one cycle, choose the next set ch_mask bit in round-robin order, starting after the last channel served and wrapping 3->0; it SHALL drive ch_sel, latch osr_sel, clear the accumulator and the sample count, then go to SETTLE.
REQ-019 SELECT SHALL return to IDLE without choosing a channel when ch_mask=0 or enable=0.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to START.
REQ-021 START SHALL assert sar_cnvst for exactly one cycle, then go to WAIT_EOC.
REQ-022 sar_cnvst SHALL never be high outside START.
REQ-023 WAIT_EOC SHALL, in a cycle where sar_eoc=1, add sar_data zero-extended into a 13-bit accumulator, increment the sample count and go to ACCUM.
REQ-024 WAIT_EOC SHALL, when EOC_TIMEOUT cycles elapse with no sar_eoc, set err_timeout, discard the channel's partial accumulation, produce no output for that channel, and go to SELECT.
REQ-025 sar_eoc SHALL be ignored in every state except WAIT_EOC.
REQ-026 ACCUM SHALL go to START, with no resettle, while the sample count is below the latched N; when the count equals N it SHALL go to OUTPUT.
REQ-027 out_data SHALL equal the accumulator shifted right by log2(N), truncated with no rounding, so it never exceeds 10'h3FF.
REQ-028 OUTPUT SHALL hold out_valid=1 with out_data and out_ch stable until out_ready=1; the transfer SHALL complete in that cycle, and OUTPUT SHALL then go to SELECT.
REQ-029 While OUTPUT waits for out_ready, no conversion SHALL start (backpressure).
REQ-030 out_ready=1 while out_valid=0 SHALL have no effect.
REQ-031 Deasserting enable mid-channel SHALL let the current channel finish through OUTPUT; the next SELECT SHALL then return to IDLE.
REQ-032 ch_mask and osr_sel SHALL be sampled only in SELECT; changes at any other time SHALL take effect on the next channel.
REQ-033 err_clr and a new timeout in the same cycle SHALL leave err_timeout=1 (set wins).

Reset
REQ-034 While rst=1, the state SHALL be IDLE; sar_cnvst=0, out_valid=0, out_data=0, out_ch=0, ch_sel=0, busy=0, err_timeout=0; the accumulator and counters SHALL be 0; the round-robin pointer SHALL be set so that channel 0 is chosen first.
REQ-035 rst in any state, including mid-OUTPUT or WAIT_EOC, SHALL abort the operation immediately with no output transfer.

Verification
REQ-036 Scenario (single conversion): ch_mask=4'b0001, osr_sel=0, out_ready=1, SAR model returns 10'h2A5 -> one out_valid with out_data=10'h2A5 and out_ch=0; sar_cnvst exactly SETTLE_CYCLES+2 cycles after enable rises.
REQ-037 Scenario (round robin): ch_mask=4'b1010, osr_sel=0 -> out_ch sequence 1,3,1,3; ch_sel changes only in SELECT.
REQ-038 Scenario (averaging): osr_sel=2, samples 100,101,102,104 -> exactly 4 sar_cnvst pulses, then out_data=101 (407>>2).
REQ-039 Scenario (backpressure): out_ready=0 for 20 cycles during OUTPUT -> out_valid and out_data stable throughout, no sar_cnvst; transfer completes on the first out_ready=1 cycle.
REQ-040 Scenario (timeout): SAR model never pulses sar_eoc, ch_mask=4'b0011 -> err_timeout set EOC_TIMEOUT cycles after sar_cnvst, no output for ch0, sequencer moves to ch1; err_clr clears the flag.
REQ-041 Scenario (reset mid-operation): rst asserted in WAIT_EOC -> next cycle busy=0 and all outputs at reset values; a late sar_eoc is ignored.
